alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide execute unit for the RV32M instructions. It sits beside the single-cycle ALU in the execute stage. The main decoder steers an R-type instruction here when funct7 = 0000001. The unit decodes funct3 itself, runs a one-bit-per-cycle shift-add or restoring-division sequence, and returns the result with a busy/done handshake so the core can stall.

---
 rtl/alu_muldiv.sv | 167 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide execute unit.
// Multiplies by one-bit-per-cycle shift-add and divides by one-bit-per-cycle
// restoring division on operand magnitudes. Signs are applied in a final FIX
// cycle. Divide by zero and signed overflow bypass the iteration.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, accepted only in IDLE or DONE
//   funct3  RV32M operation select (MUL..REMU)
//   op_a    rs1 (multiplicand / dividend)
//   op_b    rs2 (multiplier / divisor)
//   busy    operation in flight (ITER, FIX)
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next op completes
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one multiplier bit / quotient bit per cycle
// FIX   | apply signs, select word, write result
// DONE  | done pulse; start here chains the next op
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [2:0]      f3_q;
    // Multiply: {acc_hi[XLEN-1:0], acc_lo} is the running product, with the
    // multiplier shifting out of acc_lo. Divide: acc_hi is the partial
    // remainder and acc_lo shifts the dividend out and the quotient in.
    logic [XLEN:0]   acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic            neg_main;
    logic            neg_rem;

    logic            accept;
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Decode and special-case detection on the live inputs.
    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        is_div   = funct3[2];
        a_sgn    = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
        b_sgn    = a_sgn && (funct3 != 3'b010);
        a_neg    = a_sgn && op_a[XLEN-1];
        b_neg    = b_sgn && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0]
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        special  = div_zero || div_ovf;
    end

    // One iteration step and the final fix-up.
    always_comb begin
        mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? opnd : {XLEN{1'b0}})};
        div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = !div_diff[XLEN];

        prod      = {acc_hi[XLEN-1:0], acc_lo};
        prod_s    = neg_main ? -prod : prod;
        quo       = neg_main ? -acc_lo : acc_lo;
        rem       = neg_rem ? -acc_hi[XLEN-1:0] : acc_hi[XLEN-1:0];
        if (f3_q[2])
            fix_res = f3_q[1] ? rem : quo;
        else if (f3_q[1:0] == 2'b00)
            fix_res = prod_s[XLEN-1:0];
        else
            fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? FIX : ITER;
            ITER:    if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? (special ? FIX : ITER) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ITER) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            f3_q     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            f3_q     <= funct3;
            count    <= CW'(XLEN);
            acc_hi   <= '0;
            opnd     <= b_mag;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= 1'b0;
            if (div_zero) begin
                // Quotient all ones, remainder is the raw dividend.
                acc_hi   <= {1'b0, op_a};
                acc_lo   <= '1;
                neg_main <= 1'b0;
            end else if (div_ovf) begin
                acc_lo   <= op_a;
                neg_main <= 1'b0;
            end else if (is_div) begin
                acc_lo  <= a_mag;
                neg_rem <= a_neg;
            end else begin
                acc_lo <= b_mag;
                opnd   <= a_mag;
            end
        end else if (state == ITER) begin
            count <= count - 1'b1;
            if (f3_q[2]) begin
                acc_hi <= div_ge ? div_diff : div_shift;
                acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end else begin
                acc_hi <= {1'b0, mul_sum[XLEN:1]};
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
        end else if (state == FIX) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized and directed self-checking bench for alu_muldiv
// (XLEN=32) against an arithmetic reference model.
module tb_alu_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns just after the accept edge with the
    // inputs scrambled, so late input changes are exercised.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Returns at the negedge of the done cycle.
    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
        logic [31:0] exp_res;
        int          exp_lat, n, bad_busy, bad_hold;
        bit          seen;
        exp_res  = model(f3, a, b);
        exp_lat  = latency(f3, a, b);
        n        = 0;
        seen     = 0;
        bad_busy = 0;
        bad_hold = 0;
        launch(f3, a, b);
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) bad_busy++;
                if (result !== last_res) bad_hold++;
                if (poke && n == 5) begin
                    start  = 1'b1;
                    funct3 = 3'($urandom);
                    op_a   = $urandom;
                    op_b   = $urandom;
                end
                if (poke && n == 6) start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, n - 1, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_busy_iter"}, bad_busy, 0);
        chk({tag, "_hold"}, bad_hold, 0);
        last_res = exp_res;
    endtask

    task automatic tail(input string tag);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    logic [2:0]  d_f3 [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] d_a  [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
    logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

    initial begin
        int n_done;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run($sformatf("dir%0d", i), d_f3[i], d_a[i], d_b[i], 1'b0);
            tail($sformatf("dir%0d", i));
        end

        run("poke", 3'd0, 32'd123456, 32'd789, 1'b1);
        tail("poke");

        run("chain_a", 3'd5, 32'd1000, 32'd7, 1'b0);
        run("chain_b", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        tail("chain_b");

        launch(3'd0, 32'd55, 32'd66);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        last_res = '0;
        run("after_rst", 3'd1, 32'h8000_0000, 32'd3, 1'b0);
        tail("after_rst");

        for (int i = 0; i < 150; i++) begin
            run($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 1'b0);
            if ($urandom_range(0, 2) != 0) begin
                tail($sformatf("rnd%0d", i));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        tail("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
